// File: rtl/p2s_v2_if.sv
// p2s_v2_if: parallel word handshake in, framed serial stream out
interface p2s_v2_if #(parameter int W = 4);
  logic [W-1:0] din;
  logic din_valid, din_ready, start, sin, busy;
  modport master(output din, din_valid, input din_ready, start, sin, busy);
  modport slave(input din, din_valid, output din_ready, start, sin, busy);
endinterface

// File: rtl/p2s_v2.sv
// p2s_v2: MSB-first parallel-to-serial framer with a one-word holding buffer
module p2s_v2 #(parameter int W = 4) (
  input logic clk,
  input logic rst_n,
  p2s_v2_if.slave s
);
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [W-1:0] sh, sh_n, buf_data, buf_n;
  logic [CW-1:0] cnt, cnt_n;
  logic buf_full, bf_n, start_q, start_n, xfer, last;
  assign s.din_ready = !buf_full;
  assign s.start = start_q;
  assign s.sin = sh[W-1];
  assign s.busy = state == SHIFT;
  assign xfer = s.din_valid && !buf_full;
  assign last = cnt == CW'(W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      cnt <= cnt_n;
      buf_data <= buf_n;
      buf_full <= bf_n;
      start_q <= start_n;
    end
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    buf_n = buf_data;
    bf_n = buf_full;
    start_n = 1'b0;
    if (state == IDLE) begin
      if (xfer) begin
        state_n = SHIFT;
        sh_n = s.din;
        cnt_n = '0;
        start_n = 1'b1;
      end
    end else if (!last) begin
      sh_n = sh << 1;
      cnt_n = cnt + 1'b1;
      if (xfer) begin
        buf_n = s.din;
        bf_n = 1'b1;
      end
    end else if (buf_full) begin
      sh_n = buf_data;
      bf_n = 1'b0;
      cnt_n = '0;
      start_n = 1'b1;
    end else if (s.din_valid) begin
      sh_n = s.din;
      cnt_n = '0;
      start_n = 1'b1;
    end else begin
      // final shift flushes the register to zero so sin reads 0 while idle
      state_n = IDLE;
      sh_n = sh << 1;
      cnt_n = '0;
    end
  end
endmodule

// File: doc/p2s_v2.md
P2S_V2 -- requirements
Module: p2s_v2

Interface
REQ-001 Parameter W, default 4, meaning word width and frame length in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
REQ-004 din  input  W  parallel word to serialise; sampled only when din_valid && din_ready.
REQ-005 din_valid  input  1  upstream word available.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 start  output  1  frame marker; high only during the first bit of each frame.
REQ-008 sin  output  1  serial data, MSB first; feeds s2p_v2 sin directly.
REQ-009 busy  output  1  high while a frame bit is being driven on sin.

Function
REQ-010 Datapath: W-bit shift register, bit counter of ceil(log2 W) bits, one-entry holding buffer (buf_data, buf_full).
REQ-011 States: IDLE (no frame) and SHIFT (frame bit on sin); busy SHALL equal (state == SHIFT).
REQ-012 din_ready SHALL equal !buf_full (combinational from registered state).
REQ-013 Handshake: a word transfers at a rising edge where din_valid && din_ready; din must remain stable while din_valid is high and din_ready is low.
REQ-014 IDLE, transfer at edge k: word loads directly into the shifter; after edge k start=1, sin=din[W-1], busy=1, counter=0; buffer stays empty.
REQ-015 SHIFT, counter < W-1: each edge shifts left one bit, counter increments, start=0, sin=next lower bit; a transfer at that edge goes into the buffer (buf_full=1).
REQ-016 SHIFT, counter == W-1 (last bit on sin), next edge: if buf_full, load buffer into shifter, clear buf_full, start=1, counter=0; else if din_valid, load din directly, start=1, counter=0; else enter IDLE.
REQ-017 Back-to-back frames SHALL have zero idle cycles; start SHALL pulse exactly every W cycles while words are continuously available.
REQ-018 Simultaneous: on the edge of REQ-016 with buf_full=1 and a new transfer (din_ready=0 holds off, so none occurs); with buf_full=0 and din_valid=1, din loads directly and the buffer stays empty.
REQ-019 IDLE: start=0, sin=0, busy=0; shifter contents are don't-care and are never exposed on sin.
REQ-020 start, sin, busy SHALL be registered outputs (no combinational path from din/din_valid).
REQ-021 Throughput: one word per W cycles; latency from transfer edge to first bit on sin = 0 cycles after that edge when IDLE, otherwise queued behind the current frame.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, start=0, sin=0, busy=0, counter=0, buf_full=0 (din_ready=1), shifter=0.
REQ-023 Reset mid-frame SHALL discard the partial frame and any buffered word; no stale bits are emitted after release.
REQ-024 First transfer is permitted at the first rising edge after rst_n deasserts.

Verification (W=4)
REQ-025 Hold rst_n=0 for 3 cycles -> start=0, sin=0, busy=0, din_ready=1 throughout; release -> unchanged until first transfer.
REQ-026 Single word 4'b0110 in IDLE -> next 4 cycles sin=0,1,1,0, start=1,0,0,0, busy=1; then busy=0, sin=0.
REQ-027 Words (i+6) mod 16 for i=0..15, din_valid held high -> continuous 64-bit stream, start every 4th cycle, no gaps; a connected s2p_v2 reproduces all 16 words in order.
REQ-028 Three words offered on consecutive cycles starting in IDLE -> first loads, second fills buffer, din_ready=0 until the buffer empties at the frame boundary; third accepted then; all three emitted in order, back-to-back.
REQ-029 rst_n pulsed low while bit 2 of 4'b1011 is on sin, with one word buffered -> outputs 0 immediately; after release a new word 4'b1100 produces a clean frame with start=1 on its first bit and no remnant bits.
REQ-030 din_valid rises exactly in the last-bit cycle with buffer empty -> next frame starts on the following cycle with start=1, no idle cycle, buf_full stays 0.
